// File: rtl/dcache_flush_unit.sv
// Data-cache flush walker: visits every set/way, writes back valid+dirty lines,
// invalidates every line, then pulses flush_ack_o once.
module dcache_flush_unit #(
  parameter  int unsigned NR_SETS      = 256,
  parameter  int unsigned NR_WAYS      = 8,
  parameter  int unsigned TAG_WIDTH    = 44,
  parameter  int unsigned OFFSET_WIDTH = 4,
  localparam int unsigned IDX_W        = $clog2(NR_SETS),
  localparam int unsigned WAY_W        = $clog2(NR_WAYS),
  localparam int unsigned ADDR_W       = TAG_WIDTH + IDX_W + OFFSET_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  output logic                 flush_ack_o,
  output logic                 busy_o,
  output logic                 tag_req_o,
  input  logic                 tag_gnt_i,
  output logic [IDX_W-1:0]     tag_idx_o,
  output logic [WAY_W-1:0]     tag_way_o,
  input  logic                 tag_rvalid_i,
  input  logic                 tag_valid_i,
  input  logic                 tag_dirty_i,
  input  logic [TAG_WIDTH-1:0] tag_rdata_i,
  output logic                 wb_req_o,
  input  logic                 wb_gnt_i,
  output logic [ADDR_W-1:0]    wb_addr_o,
  output logic                 inv_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_REQ,
    S_READ_WAIT,
    S_WB_REQ,
    S_INV,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [WAY_W-1:0]     way_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 armed_q;
  logic                 last_way;
  logic                 last_line;

  assign last_way  = (way_q == WAY_W'(NR_WAYS - 1));
  assign last_line = last_way && (idx_q == IDX_W'(NR_SETS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tag_req_o   = 1'b0;
    wb_req_o    = 1'b0;
    inv_o       = 1'b0;
    flush_ack_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i && armed_q) state_d = S_READ_REQ;
      end
      S_READ_REQ: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (tag_rvalid_i) state_d = (tag_valid_i && tag_dirty_i) ? S_WB_REQ : S_INV;
      end
      S_WB_REQ: begin
        wb_req_o = 1'b1;
        if (wb_gnt_i) state_d = S_INV;
      end
      S_INV: begin
        inv_o   = 1'b1;
        state_d = last_line ? S_DONE : S_READ_REQ;
      end
      S_DONE: begin
        flush_ack_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Walk counters, latched tag and the re-arm flag. armed_q blocks the trailing
  // high cycle of the registered flush request from restarting a second walk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!flush_i) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            idx_q   <= '0;
            way_q   <= '0;
            armed_q <= 1'b0;
          end
        end
        S_READ_WAIT: begin
          if (tag_rvalid_i) tag_q <= tag_rdata_i;
        end
        S_INV: begin
          way_q <= way_q + WAY_W'(1);
          if (last_way) idx_q <= idx_q + IDX_W'(1);
        end
        S_DONE: begin
          idx_q <= '0;
          way_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign tag_idx_o = idx_q;
  assign tag_way_o = way_q;
  assign wb_addr_o = {tag_q, idx_q, {OFFSET_WIDTH{1'b0}}};

endmodule
